// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the RVFI trace FIFO.
//   TRACE_WORDS_BASE / TRACE_WORDS_MEM : words per record without / with memory fields
//   TRACE_WORDS      : words per record in this build (IBEX_TRACE_MEM_EN selects 6)
//   trace_ser_e      : serializer states
//   trace_rec_t      : packed record held in the FIFO
//   trace_word()     : selects stream word idx of a stored record
// Optional feature macro: IBEX_TRACE_MEM_EN (adds mem_addr and mem data words).
package ibex_pkg;

    localparam int TRACE_WORDS_BASE = 4;
    localparam int TRACE_WORDS_MEM  = 6;

`ifdef IBEX_TRACE_MEM_EN
    localparam int TRACE_WORDS = TRACE_WORDS_MEM;
`else
    localparam int TRACE_WORDS = TRACE_WORDS_BASE;
`endif

    typedef enum logic {
        TRACE_IDLE = 1'b0,
        TRACE_SEND = 1'b1
    } trace_ser_e;

    typedef struct packed {
        logic [7:0]  order;
`ifdef IBEX_TRACE_MEM_EN
        logic [3:0]  rmask;
        logic [3:0]  wmask;
`endif
        logic [4:0]  rd_addr;
        logic        trap;
        logic        intr;
        logic        halt;
        logic [1:0]  mode;
        logic        ovf;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
`ifdef IBEX_TRACE_MEM_EN
        logic [31:0] mem_addr;
        logic [31:0] mem_data;  // wdata for stores, rdata otherwise
`endif
    } trace_rec_t;

    function automatic logic [31:0] trace_word(trace_rec_t rec, logic [2:0] idx);
        logic [31:0] word;
        word = '0;
        case (idx)
`ifdef IBEX_TRACE_MEM_EN
            3'd0: word = {rec.order, rec.rmask, rec.wmask, rec.rd_addr, rec.trap,
                          rec.intr, rec.halt, rec.mode, rec.ovf, 5'(TRACE_WORDS)};
            3'd4: word = rec.mem_addr;
            3'd5: word = rec.mem_data;
`else
            3'd0: word = {rec.order, 8'h00, rec.rd_addr, rec.trap,
                          rec.intr, rec.halt, rec.mode, rec.ovf, 5'(TRACE_WORDS)};
`endif
            3'd1: word = rec.pc;
            3'd2: word = rec.insn;
            3'd3: word = rec.rd_wdata;
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// ibex_trace_rec_fifo: generic single-clock FIFO.
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write request and data (accepted when not full, or when popping)
//   pop           : remove head entry (ignored when empty)
//   rdata         : head entry, combinational from storage
//   full, empty, count : occupancy status
module ibex_trace_rec_fifo #(
    parameter int Depth = 4,
    parameter int Width = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [Width-1:0] mem [Depth];
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the write.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ibex_rvfi_trace_fifo.sv
// ibex_rvfi_trace_fifo: captures RVFI retirement records into a FIFO and
// serialises them as 32-bit words on a valid/ready stream. Never stalls the core:
// records arriving at a full FIFO are dropped, counted, and flagged (ovf) in the
// header of the next accepted record.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   trace_en_i          : capture enable
//   rvfi_*              : retirement port inputs
//   trace_valid_o/ready_i/data_o/last_o : output word stream
//   drop_cnt_o          : saturating dropped-record count
//   fifo_empty_o        : no stored records and serializer idle
// Optional feature macro: IBEX_TRACE_MEM_EN (6-word records with memory fields).
//
// Serializer states:
//   state      | meaning
//   TRACE_IDLE | nothing to send
//   TRACE_SEND | presenting word idx of the head record
module ibex_rvfi_trace_fifo #(
    parameter int FifoDepth    = 4,
    parameter int DropCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    trace_en_i,
    input  logic                    rvfi_valid,
    input  logic [63:0]             rvfi_order,
    input  logic [31:0]             rvfi_insn,
    input  logic                    rvfi_trap,
    input  logic                    rvfi_halt,
    input  logic                    rvfi_intr,
    input  logic [1:0]              rvfi_mode,
    input  logic [4:0]              rvfi_rd_addr,
    input  logic [31:0]             rvfi_rd_wdata,
    input  logic [31:0]             rvfi_pc_rdata,
    input  logic [31:0]             rvfi_mem_addr,
    input  logic [3:0]              rvfi_mem_rmask,
    input  logic [3:0]              rvfi_mem_wmask,
    input  logic [31:0]             rvfi_mem_rdata,
    input  logic [31:0]             rvfi_mem_wdata,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [31:0]             trace_data_o,
    output logic                    trace_last_o,
    output logic [DropCntWidth-1:0] drop_cnt_o,
    output logic                    fifo_empty_o
);

    import ibex_pkg::*;

    localparam int CW = $clog2(FifoDepth) + 1;
    localparam logic [2:0] LAST_IDX = 3'(TRACE_WORDS - 1);

    trace_ser_e              state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    trace_rec_t              rec_in;
    trace_rec_t              rec_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic                    push_req;
    logic                    push_ok;
    logic                    drop;
    logic                    handshake;
    logic                    pop;
    logic                    have_next;
    logic                    ovf_q;
    logic [DropCntWidth-1:0] drop_cnt_q;

    logic unused_order;
    assign unused_order = ^rvfi_order[63:8];
`ifndef IBEX_TRACE_MEM_EN
    logic unused_mem;
    assign unused_mem = ^{rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
                          rvfi_mem_rdata, rvfi_mem_wdata};
`endif

    always_comb begin
        rec_in          = '0;
        rec_in.order    = rvfi_order[7:0];
        rec_in.rd_addr  = rvfi_rd_addr;
        rec_in.trap     = rvfi_trap;
        rec_in.intr     = rvfi_intr;
        rec_in.halt     = rvfi_halt;
        rec_in.mode     = rvfi_mode;
        rec_in.ovf      = ovf_q;
        rec_in.pc       = rvfi_pc_rdata;
        rec_in.insn     = rvfi_insn;
        rec_in.rd_wdata = rvfi_rd_wdata;
`ifdef IBEX_TRACE_MEM_EN
        rec_in.rmask    = rvfi_mem_rmask;
        rec_in.wmask    = rvfi_mem_wmask;
        rec_in.mem_addr = rvfi_mem_addr;
        rec_in.mem_data = (rvfi_mem_wmask != 4'h0) ? rvfi_mem_wdata : rvfi_mem_rdata;
`endif
    end

    assign push_req  = rvfi_valid & trace_en_i;
    assign handshake = (state_q == TRACE_SEND) & trace_ready_i;
    assign pop       = handshake & (idx_q == LAST_IDX);
    assign push_ok   = push_req & (~fifo_full | pop);
    assign drop      = push_req & ~push_ok;
    // Records remaining after this edge; a same-edge push lets the serializer
    // move straight into the new record with no idle cycle.
    assign have_next = push_ok | (fifo_count != CW'(pop));

    ibex_trace_rec_fifo #(
        .Depth (FifoDepth),
        .Width ($bits(trace_rec_t))
    ) u_rec_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_req),
        .wdata (rec_in),
        .pop   (pop),
        .rdata (rec_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TRACE_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            TRACE_IDLE: begin
                idx_d = '0;
                if (have_next) state_d = TRACE_SEND;
            end
            TRACE_SEND: begin
                if (handshake) begin
                    if (pop) begin
                        idx_d = '0;
                        if (!have_next) state_d = TRACE_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = TRACE_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        trace_valid_o = 1'b0;
        trace_data_o  = '0;
        trace_last_o  = 1'b0;
        fifo_empty_o  = fifo_empty;
        if (state_q == TRACE_SEND) begin
            trace_valid_o = 1'b1;
            trace_data_o  = trace_word(rec_head, idx_q);
            trace_last_o  = (idx_q == LAST_IDX);
            fifo_empty_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
                if (!(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
            end else if (push_ok) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
module tb_ibex_rvfi_trace_fifo;

    localparam int DEPTH = 4;
`ifdef IBEX_TRACE_MEM_EN
    localparam int NW = 6;
`else
    localparam int NW = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_en;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
    logic        trace_valid, trace_ready, trace_last, fifo_empty;
    logic [31:0] trace_data;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    ibex_rvfi_trace_fifo #(.FifoDepth(DEPTH), .DropCntWidth(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .trace_en_i     (trace_en),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_trap      (rvfi_trap),
        .rvfi_halt      (rvfi_halt),
        .rvfi_intr      (rvfi_intr),
        .rvfi_mode      (rvfi_mode),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_rmask (rvfi_mem_rmask),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .rvfi_mem_rdata (rvfi_mem_rdata),
        .rvfi_mem_wdata (rvfi_mem_wdata),
        .trace_valid_o  (trace_valid),
        .trace_ready_i  (trace_ready),
        .trace_data_o   (trace_data),
        .trace_last_o   (trace_last),
        .drop_cnt_o     (drop_cnt),
        .fifo_empty_o   (fifo_empty)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of whole records (word i at bits [32*i +: 32]),
    // the word index of the head record, the pending-gap flag and drop count.
    logic [191:0] mq[$];
    int           sidx  = 0;
    bit           movf  = 0;
    int           mdrop = 0;

    function automatic logic [191:0] build_rec();
        logic [191:0] r;
        logic [3:0]   rm, wm;
`ifdef IBEX_TRACE_MEM_EN
        rm = rvfi_mem_rmask;
        wm = rvfi_mem_wmask;
`else
        rm = 4'h0;
        wm = 4'h0;
`endif
        r = '0;
        r[31:0]   = {rvfi_order[7:0], rm, wm, rvfi_rd_addr, rvfi_trap, rvfi_intr,
                     rvfi_halt, rvfi_mode, movf, 5'(NW)};
        r[63:32]  = rvfi_pc_rdata;
        r[95:64]  = rvfi_insn;
        r[127:96] = rvfi_rd_wdata;
`ifdef IBEX_TRACE_MEM_EN
        r[159:128] = rvfi_mem_addr;
        r[191:160] = (wm != 4'h0) ? rvfi_mem_wdata : rvfi_mem_rdata;
`endif
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit hs, pp;
        if (rst) begin
            mq.delete();
            sidx  = 0;
            movf  = 0;
            mdrop = 0;
        end else begin
            hs = (mq.size() > 0) && trace_ready;
            pp = hs && (sidx == NW - 1);
            if (hs) sidx = pp ? 0 : sidx + 1;
            if (pp) void'(mq.pop_front());
            if (rvfi_valid && trace_en) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(build_rec());
                    movf = 0;
                end else begin
                    if (mdrop < 65535) mdrop++;
                    movf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [191:0] h;
        if (!rst) begin
            chk("valid", trace_valid, mq.size() > 0);
            chk("fifo_empty", fifo_empty, mq.size() == 0);
            chk("drop_cnt", drop_cnt, mdrop);
            if (mq.size() > 0) begin
                h = mq[0];
                chk("data", trace_data, h[sidx*32 +: 32]);
                chk("last", trace_last, sidx == NW - 1);
            end else begin
                chk("last_idle", trace_last, 0);
            end
        end
    end

    task automatic drive(input logic [7:0] ord, input logic [31:0] pc, input logic [31:0] insn,
                         input logic [4:0] rd, input logic [31:0] wd);
        rvfi_valid     = 1'b1;
        rvfi_order     = {56'h0, ord};
        rvfi_pc_rdata  = pc;
        rvfi_insn      = insn;
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = wd;
        rvfi_trap      = 1'b0;
        rvfi_halt      = 1'b0;
        rvfi_intr      = 1'b0;
        rvfi_mode      = 2'b00;
        rvfi_mem_addr  = '0;
        rvfi_mem_rmask = '0;
        rvfi_mem_wmask = '0;
        rvfi_mem_rdata = '0;
        rvfi_mem_wdata = '0;
    endtask

    task automatic drain(input string name);
        int k;
        rvfi_valid  = 1'b0;
        trace_ready = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (fifo_empty) break;
        end
        chk(name, fifo_empty, 1);
        @(posedge clk); #1;
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_w [6];
        trace_en    = 1'b1;
        trace_ready = 1'b1;
        drive(8'h0, 32'h0, 32'h0, 5'h0, 32'h0);
        rvfi_valid  = 1'b0;

        @(posedge clk); #1;
        chk("rst_valid", trace_valid, 0);
        chk("rst_last", trace_last, 0);
        chk("rst_data", trace_data, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_empty", fifo_empty, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single retirement, literal words.
`ifdef IBEX_TRACE_MEM_EN
        exp_w = '{32'h00000806, 32'h80, 32'h00500093, 32'h5, 32'h0, 32'h0};
`else
        exp_w = '{32'h00000804, 32'h80, 32'h00500093, 32'h5, 32'h0, 32'h0};
`endif
        drive(8'h0, 32'h80, 32'h00500093, 5'd1, 32'h5);
        @(posedge clk); #1;
        rvfi_valid = 1'b0;
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            chk("single_data", trace_data, exp_w[i]);
            chk("single_last", trace_last, i == NW - 1);
        end
        @(posedge clk); #1;

        // Back-pressure on word1.
        drive(8'h1, 32'h80, 32'h00500093, 5'd1, 32'h5);
        @(posedge clk); #1;
        rvfi_valid = 1'b0;
        @(posedge clk); #1;
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data", trace_data, 32'h80);
            chk("bp_valid", trace_valid, 1);
        end
        @(posedge clk); #1;
        drain("bp_drain");

        // Overflow: six retirements into a 4-deep FIFO.
        trace_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(8'(16 + i), 32'h100 + 32'(i), 32'h13, 5'd2, 32'(i));
            @(posedge clk); #1;
        end
        rvfi_valid = 1'b0;
        @(negedge clk);
        chk("ovf_drop_cnt", drop_cnt, 2);
        @(posedge clk); #1;
        drain("ovf_drain");
        drive(8'h30, 32'h200, 32'h13, 5'd3, 32'h7);
        @(posedge clk); #1;
        rvfi_valid = 1'b0;
        @(negedge clk);
        chk("ovf_hdr_bit5_set", trace_data[5], 1);
        @(posedge clk); #1;
        drain("ovf_drain2");
        drive(8'h31, 32'h204, 32'h13, 5'd3, 32'h8);
        @(posedge clk); #1;
        rvfi_valid = 1'b0;
        @(negedge clk);
        chk("ovf_hdr_bit5_clr", trace_data[5], 0);
        @(posedge clk); #1;
        drain("ovf_drain3");

        // Push into a full FIFO on the same edge as the last-word handshake.
        trace_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(8'(64 + i), 32'h300 + 32'(i), 32'h33, 5'd4, 32'(i));
            @(posedge clk); #1;
        end
        rvfi_valid  = 1'b0;
        trace_ready = 1'b1;
        begin : wait_last
            int k;
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (trace_last) break;
            end
            chk("coinc_last_seen", trace_last, 1);
        end
        drive(8'h50, 32'h400, 32'h44, 5'd5, 32'h9);
        @(posedge clk); #1;
        rvfi_valid = 1'b0;
        @(negedge clk);
        chk("coinc_drop_cnt", drop_cnt, 2);
        @(posedge clk); #1;
        drain("coinc_drain");

        // Capture disabled.
        trace_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'(80 + i), 32'h500, 32'h55, 5'd6, 32'h1);
            @(negedge clk);
            chk("en0_valid", trace_valid, 0);
            @(posedge clk); #1;
        end
        rvfi_valid = 1'b0;
        trace_en   = 1'b1;
        @(negedge clk);
        chk("en0_valid_after", trace_valid, 0);
        chk("en0_drop_cnt", drop_cnt, 2);
        @(posedge clk); #1;

`ifdef IBEX_TRACE_MEM_EN
        drive(8'h60, 32'h600, 32'h0000a023, 5'd0, 32'h0);
        rvfi_mem_addr  = 32'h1000;
        rvfi_mem_wmask = 4'hF;
        rvfi_mem_wdata = 32'hDEADBEEF;
        rvfi_mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        rvfi_valid = 1'b0;
        @(negedge clk);
        chk("mem_hdr_wmask", trace_data[19:16], 4'hF);
        chk("mem_hdr_count", trace_data[4:0], 5'd6);
        repeat (4) @(negedge clk);
        chk("mem_word4", trace_data, 32'h1000);
        @(negedge clk);
        chk("mem_word5", trace_data, 32'hDEADBEEF);
        chk("mem_last", trace_last, 1);
        @(posedge clk); #1;
        drain("mem_drain");
`endif

        // Reset mid-record.
        drive(8'h70, 32'h700, 32'h77, 5'd7, 32'h7);
        @(posedge clk); #1;
        rvfi_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", trace_valid, 0);
        chk("midrst_last", trace_last, 0);
        chk("midrst_data", trace_data, 0);
        chk("midrst_drop", drop_cnt, 0);
        chk("midrst_empty", fifo_empty, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomised traffic; the first half keeps ready mostly low to force drops.
        for (int c = 0; c < 1500; c++) begin
            rvfi_valid     = ($urandom_range(0, 9) < 6);
            trace_en       = ($urandom_range(0, 7) != 0);
            trace_ready    = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rvfi_order     = {$urandom, $urandom};
            rvfi_insn      = $urandom;
            rvfi_trap      = 1'($urandom);
            rvfi_halt      = 1'($urandom);
            rvfi_intr      = 1'($urandom);
            rvfi_mode      = 2'($urandom);
            rvfi_rd_addr   = 5'($urandom);
            rvfi_rd_wdata  = $urandom;
            rvfi_pc_rdata  = $urandom;
            rvfi_mem_addr  = $urandom;
            rvfi_mem_rmask = 4'($urandom);
            rvfi_mem_wmask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            rvfi_mem_rdata = $urandom;
            rvfi_mem_wdata = $urandom;
            @(posedge clk); #1;
        end
        trace_en = 1'b1;
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_rvfi_trace_fifo.md
Name: ibex_rvfi_trace_fifo

Overview:
- Sits directly downstream of the core's RVFI retirement port, as a sibling consumer to the text tracer.
- Captures each retired-instruction record into a record FIFO.
- Serialises each record into 32-bit words on a valid/ready stream, for an off-chip trace port or a DMA sink.
- Never back-pressures the core. When the FIFO is full, records are dropped and counted, and a flag marks the stream gap.

Parameters:
- FifoDepth, 4, record capacity; power of two, >=2.
- DropCntWidth, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- trace_en_i  in  1  capture enable; when low, records are ignored and not counted as drops
- rvfi_valid  in  1  retirement strobe
- rvfi_order  in  64  retirement index; only [7:0] is used
- rvfi_insn  in  32  instruction word
- rvfi_trap  in  1  trap flag
- rvfi_halt  in  1  halt flag
- rvfi_intr  in  1  interrupt flag
- rvfi_mode  in  2  privilege mode
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  writeback data
- rvfi_pc_rdata  in  32  PC of the retired instruction
- rvfi_mem_addr  in  32  memory address
- rvfi_mem_rmask  in  4  memory read mask
- rvfi_mem_wmask  in  4  memory write mask
- rvfi_mem_rdata  in  32  memory read data
- rvfi_mem_wdata  in  32  memory write data
- trace_valid_o  out  1  stream word valid
- trace_ready_i  in  1  sink ready
- trace_data_o  out  32  stream word
- trace_last_o  out  1  final word of a record
- drop_cnt_o  out  DropCntWidth  saturating count of dropped records
- fifo_empty_o  out  1  FIFO holds no records and no record is being sent

Behaviour:
- Reset (asynchronous, rst_i high):
  - trace_valid_o=0, trace_last_o=0, trace_data_o=0, drop_cnt_o=0, fifo_empty_o=1.
  - FIFO pointers cleared, overflow flag cleared, serializer in IDLE.
  - Reset mid-record discards the record; there is no partial recovery.
- Push condition: rvfi_valid & trace_en_i. The packed record is written in the same edge.
- Full FIFO:
  - The record is dropped, drop_cnt_o increments (saturates at all-ones) and the sticky ovf flag is set.
  - ovf is written into the next accepted record's header, then cleared.
- Simultaneous push while full and pop of a record (last word handshake) in the same cycle: the push is accepted and the count is unchanged.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, load the head record and go to SEND with idx=0.
  - SEND: trace_valid_o=1 and trace_data_o=word[idx].
    - The word is held stable while valid & !ready.
    - On handshake, idx increments.
    - On handshake of the last word (trace_last_o=1), pop the record. If the FIFO is non-empty after the pop, reload and stay in SEND with idx=0 (no bubble); otherwise go to IDLE.
- Latency: a record pushed at edge N has its first word valid in the cycle after edge N, i.e. one cycle minimum.
- Record layout:
  - word0 header:
    - [31:24] order[7:0]
    - [23:20] rmask
    - [19:16] wmask
    - [15:11] rd_addr
    - [10] trap
    - [9] intr
    - [8] halt
    - [7:6] mode
    - [5] ovf
    - [4:0] record word count (4 or 6)
  - word1 pc_rdata; word2 insn; word3 rd_wdata.
- fifo_empty_o = FIFO count==0 & FSM in IDLE.
- Pointers wrap modulo FifoDepth, with an extra wrap bit to tell full from empty.

Optional Feature:
- Macro IBEX_TRACE_MEM_EN.
- Defined:
  - Records are 6 words: word4 mem_addr; word5 = mem_wdata if wmask!=0, else mem_rdata.
  - Header masks populated; word count=6.
- Undefined:
  - Mem fields are neither stored nor sent; records are 4 words.
  - Header [23:16]=0; word count=4.

Decomposition:
- Shared package (ibex_pkg): typedef trace_rec_t (packed record), constants TRACE_WORDS_BASE=4 and TRACE_WORDS_MEM=6, and serializer state enum trace_ser_e {TRACE_IDLE, TRACE_SEND}.
- One natural sub-module: ibex_trace_rec_fifo, a generic single-clock FIFO with full/empty/count. Serializer and drop logic live in the top.

Test Plan:
- Single retirement, pc=0x80, insn=0x00500093, rd=1, wdata=5, ready=1 -> 4 words over consecutive cycles starting one cycle later: header 0x00000804 (order 0), 0x80, 0x00500093, 0x5; last on word3.
- Back-pressure: ready held low for 3 cycles on word1 -> trace_data_o stays 0x80 and valid stays 1; sequence resumes intact.
- Overflow: ready=0, 6 retirements with FifoDepth=4 -> drop_cnt_o=2; the 5th and 6th are lost. Drain, then retire again -> that record's header bit5=1, and the next record has bit5=0.
- Push while full coincident with the last-word handshake -> push accepted, drop_cnt_o unchanged.
- trace_en_i=0 during 3 retirements -> no output and drop_cnt_o unchanged. Assert rst_i mid-record -> all outputs return to reset values immediately.
- With IBEX_TRACE_MEM_EN: store, wmask=0xF, addr 0x1000, wdata 0xDEADBEEF -> 6 words; header [19:16]=0xF, count=6; word4 0x1000; word5 0xDEADBEEF.
